// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lif_pkg
// Description : Shared types and constants for the LIF neuron controller.
// Revision    : 1.0
// ============================================================================
package lif_pkg;

    localparam int LIF_WIDTH = 8;

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REFRAC = 2'd3
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/lif_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lif_rr_arbiter
// Description : Round-robin one-hot arbiter; search starts at the pointer,
//               which moves one past the winner on every grant.
// Revision    : 1.0
// ============================================================================
module lif_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_k;
    logic             w_found;
    logic [N_REQ-1:0] w_gnt;

    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = PW'((int'(r_ptr) + i) % N_REQ);
            if (enable && !w_found && req[w_k]) begin
                w_found    = 1'b1;
                w_gnt[w_k] = 1'b1;
                w_idx      = w_k;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/lif_neuron_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_ctrl
// Description : Serial parameter loader, synapse round-robin scheduler and
//               refractory/spike-count controller for one LIF neuron core.
// Revision    : 1.0
// ============================================================================
module lif_neuron_ctrl
    import lif_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = LIF_WIDTH,
    parameter int REFRAC_CYC = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_decay,
    input  logic [WIDTH-1:0] cfg_weight,
    input  logic [WIDTH-1:0] cfg_thresh,
    input  logic [N_REQ-1:0] spk_req,
    output logic [N_REQ-1:0] spk_gnt,
    output logic             set_vars,
    output logic             expd,
    output logic             w,
    output logic             t,
    output logic             syn,
    input  logic             axon,
    output logic             configured,
    output logic [CNT_W-1:0] spike_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = $clog2(REFRAC_CYC + 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [WIDTH-1:0] r_sh_decay;
    logic [WIDTH-1:0] r_sh_weight;
    logic [WIDTH-1:0] r_sh_thresh;
    logic [BW-1:0]    r_bit_cnt;
    logic [RW-1:0]    r_refrac_cnt;

    logic w_xfer;
    logic w_load_done;
    logic w_refrac_done;
    logic w_spike;
    logic w_arb_en;

    assign cfg_ready     = (r_state == UNCFG) || (r_state == RUN);
    assign w_xfer        = cfg_valid && cfg_ready;
    assign w_load_done   = (r_state == LOAD) && (r_bit_cnt == BW'(WIDTH - 1));
    assign w_refrac_done = (r_state == REFRAC) && (r_refrac_cnt == RW'(1));
    assign w_spike       = axon && ((r_state == RUN) || (r_state == REFRAC));
    // A config transfer or an axon pulse pre-empts the synapse in the same cycle.
    assign w_arb_en      = (r_state == RUN) && !w_xfer && !axon;

    lif_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (spk_req),
        .enable (w_arb_en),
        .gnt    (spk_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UNCFG;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            UNCFG:   if (w_xfer) w_next_state = LOAD;
            LOAD:    if (w_load_done) w_next_state = RUN;
            RUN: begin
                if (w_xfer) begin
                    w_next_state = LOAD;
                end else if (axon) begin
                    w_next_state = REFRAC;
                end
            end
            REFRAC:  if (w_refrac_done) w_next_state = RUN;
            default: w_next_state = UNCFG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_vars     <= 1'b0;
            expd         <= 1'b0;
            w            <= 1'b0;
            t            <= 1'b0;
            syn          <= 1'b0;
            configured   <= 1'b0;
            spike_cnt    <= '0;
            r_sh_decay   <= '0;
            r_sh_weight  <= '0;
            r_sh_thresh  <= '0;
            r_bit_cnt    <= '0;
            r_refrac_cnt <= '0;
        end else begin
            syn <= |spk_gnt;

            if (w_spike && (spike_cnt != '1)) begin
                spike_cnt <= spike_cnt + 1'b1;
            end

            // Bit 0 goes straight out so LOAD cycle i presents bit i.
            if (w_xfer) begin
                set_vars    <= 1'b1;
                expd        <= cfg_decay[0];
                w           <= cfg_weight[0];
                t           <= cfg_thresh[0];
                r_sh_decay  <= cfg_decay >> 1;
                r_sh_weight <= cfg_weight >> 1;
                r_sh_thresh <= cfg_thresh >> 1;
                r_bit_cnt   <= '0;
                configured  <= 1'b0;
            end else if (r_state == LOAD) begin
                if (w_load_done) begin
                    set_vars   <= 1'b0;
                    expd       <= 1'b0;
                    w          <= 1'b0;
                    t          <= 1'b0;
                    configured <= 1'b1;
                end else begin
                    expd        <= r_sh_decay[0];
                    w           <= r_sh_weight[0];
                    t           <= r_sh_thresh[0];
                    r_sh_decay  <= r_sh_decay >> 1;
                    r_sh_weight <= r_sh_weight >> 1;
                    r_sh_thresh <= r_sh_thresh >> 1;
                    r_bit_cnt   <= r_bit_cnt + 1'b1;
                end
            end

            if ((r_state == RUN) && axon && !w_xfer) begin
                r_refrac_cnt <= RW'(REFRAC_CYC);
            end else if (r_state == REFRAC) begin
                r_refrac_cnt <= r_refrac_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_neuron_ctrl
// Description : Directed plus randomized bench for lif_neuron_ctrl against a
//               cycle-level behavioural model of the controller.
// Revision    : 1.0
// ============================================================================
module tb_lif_neuron_ctrl;

    localparam int N_REQ      = 4;
    localparam int WIDTH      = 8;
    localparam int REFRAC_CYC = 4;
    localparam int CNT_W      = 16;

    localparam int M_UNCFG  = 0;
    localparam int M_LOAD   = 1;
    localparam int M_RUN    = 2;
    localparam int M_REFRAC = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_decay;
    logic [WIDTH-1:0] cfg_weight;
    logic [WIDTH-1:0] cfg_thresh;
    logic [N_REQ-1:0] spk_req;
    logic [N_REQ-1:0] spk_gnt;
    logic             set_vars;
    logic             expd;
    logic             w;
    logic             t;
    logic             syn;
    logic             axon;
    logic             configured;
    logic [CNT_W-1:0] spike_cnt;

    always #5 clk = ~clk;

    lif_neuron_ctrl #(
        .N_REQ      (N_REQ),
        .WIDTH      (WIDTH),
        .REFRAC_CYC (REFRAC_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_decay  (cfg_decay),
        .cfg_weight (cfg_weight),
        .cfg_thresh (cfg_thresh),
        .spk_req    (spk_req),
        .spk_gnt    (spk_gnt),
        .set_vars   (set_vars),
        .expd       (expd),
        .w          (w),
        .t          (t),
        .syn        (syn),
        .axon       (axon),
        .configured (configured),
        .spike_cnt  (spike_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: mode, load position, remaining refractory cycles.
    int         m_mode;
    int         m_pos;
    int         m_refrac;
    int         m_ptr;
    int         m_cnt;
    logic       m_cfgd;
    logic       m_syn;
    logic [7:0] m_dec, m_wt, m_th;
    logic [3:0] m_last_gnt;

    logic [3:0] o_gnt;
    logic       o_expd, o_w, o_t, o_sv, o_syn, o_cfgd;

    task automatic model_reset();
        m_mode = M_UNCFG; m_pos = 0; m_refrac = 0; m_ptr = 0; m_cnt = 0;
        m_cfgd = 1'b0; m_syn = 1'b0; m_dec = '0; m_wt = '0; m_th = '0;
        m_last_gnt = '0;
    endtask

    function automatic logic [3:0] m_grant(input logic cv, input logic [3:0] rq, input logic ax);
        logic [3:0] g;
        g = '0;
        if (m_mode == M_RUN && !cv && !ax) begin
            for (int i = 0; i < N_REQ; i++) begin
                int k;
                k = (m_ptr + i) % N_REQ;
                if (g == '0 && rq[k]) g[k] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_update(input logic cv, input logic [7:0] d, input logic [7:0] wt,
                                input logic [7:0] th, input logic ax, input logic [3:0] g);
        logic xfer;
        xfer  = cv && (m_mode == M_UNCFG || m_mode == M_RUN);
        m_syn = |g;
        for (int i = 0; i < N_REQ; i++) if (g[i]) m_ptr = (i + 1) % N_REQ;
        if (ax && (m_mode == M_RUN || m_mode == M_REFRAC) && m_cnt < 65535) m_cnt++;
        if (xfer) begin
            m_dec = d; m_wt = wt; m_th = th;
            m_mode = M_LOAD; m_pos = 0; m_cfgd = 1'b0;
        end else if (m_mode == M_LOAD) begin
            m_pos++;
            if (m_pos == WIDTH) begin
                m_mode = M_RUN; m_cfgd = 1'b1;
            end
        end else if (m_mode == M_RUN && ax) begin
            m_mode = M_REFRAC; m_refrac = REFRAC_CYC;
        end else if (m_mode == M_REFRAC) begin
            m_refrac--;
            if (m_refrac == 0) m_mode = M_RUN;
        end
    endtask

    // One clock: drive on the falling edge, check, then advance the model.
    task automatic step(input logic cv, input logic [7:0] d, input logic [7:0] wt,
                        input logic [7:0] th, input logic [3:0] rq, input logic ax);
        logic [3:0] g;
        logic       ld;
        @(negedge clk);
        cfg_valid = cv; cfg_decay = d; cfg_weight = wt; cfg_thresh = th;
        spk_req = rq; axon = ax;
        #1;
        g  = m_grant(cv, rq, ax);
        ld = (m_mode == M_LOAD);
        check_val("spk_gnt",    spk_gnt,    g);
        check_val("cfg_ready",  cfg_ready,  (m_mode == M_UNCFG || m_mode == M_RUN));
        check_val("set_vars",   set_vars,   ld);
        check_val("expd",       expd,       ld ? m_dec[m_pos] : 1'b0);
        check_val("w",          w,          ld ? m_wt[m_pos]  : 1'b0);
        check_val("t",          t,          ld ? m_th[m_pos]  : 1'b0);
        check_val("syn",        syn,        m_syn);
        check_val("configured", configured, m_cfgd);
        check_val("spike_cnt",  spike_cnt,  m_cnt);
        o_gnt = spk_gnt; o_expd = expd; o_w = w; o_t = t; o_sv = set_vars;
        o_syn = syn; o_cfgd = configured;
        m_last_gnt = g;
        @(posedge clk);
        model_update(cv, d, wt, th, ax, g);
    endtask

    logic [7:0] v_e, v_w, v_t;
    int         sv_cnt;
    logic [3:0] exp_seq [5];
    logic [3:0] req;
    logic       rcv, rax;

    initial begin
        cfg_valid = 1'b0; cfg_decay = '0; cfg_weight = '0; cfg_thresh = '0;
        spk_req = 4'b1111; axon = 1'b0;
        model_reset();
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with all requests pending: nothing may be granted before config.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) step(1'b0, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0);

        // Serial load of A5/3C/80.
        step(1'b1, 8'hA5, 8'h3C, 8'h80, 4'b0000, 1'b0);
        sv_cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
            v_e[i] = o_expd; v_w[i] = o_w; v_t[i] = o_t;
            if (o_sv) sv_cnt++;
        end
        check_val("load_expd_bits", v_e, 8'hA5);
        check_val("load_w_bits",    v_w, 8'h3C);
        check_val("load_t_bits",    v_t, 8'h80);
        check_val("load_sv_cycles", sv_cnt, WIDTH);

        // Round robin with every requester active.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0);
            check_val("rr_all_gnt", o_gnt, exp_seq[i]);
            if (i == 0) check_val("run_configured", o_cfgd, 1'b1);
            if (i > 0)  check_val("rr_all_syn", o_syn, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b0);
            check_val("rr_single_gnt", o_gnt, 4'b0100);
        end

        // Axon pulse: grant blocked for the spike cycle plus the refractory window.
        step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0011, 1'b1);
        check_val("axon_gnt", o_gnt, 4'b0000);
        for (int i = 0; i < REFRAC_CYC; i++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0011, 1'b0);
            check_val("refrac_gnt", o_gnt, 4'b0000);
            check_val("refrac_syn", o_syn, 1'b0);
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0011, 1'b0);
        check_val("post_refrac_gnt", o_gnt, 4'b0001);
        check_val("post_refrac_syn", o_syn, 1'b0);
        check_val("post_refrac_cnt", spike_cnt, 1);

        // Config beats a pending request, which is served right after the load.
        step(1'b1, 8'h12, 8'h34, 8'h56, 4'b0001, 1'b0);
        check_val("cfg_wins_gnt", o_gnt, 4'b0000);
        for (int i = 0; i < WIDTH; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0);
        check_val("after_load_gnt", o_gnt, 4'b0001);

        // Asynchronous reset on LOAD cycle 3.
        step(1'b1, 8'h5A, 8'hC3, 8'hFF, 4'b0000, 1'b0);
        repeat (3) step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        @(negedge clk);
        check_val("pre_rst_set_vars", set_vars, 1'b1);
        rst = 1'b1;
        #1;
        check_val("rst_set_vars",   set_vars,   1'b0);
        check_val("rst_expd",       expd,       1'b0);
        check_val("rst_w",          w,          1'b0);
        check_val("rst_t",          t,          1'b0);
        check_val("rst_configured", configured, 1'b0);
        check_val("rst_spike_cnt",  spike_cnt,  0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'hA5, 8'h3C, 8'h80, 4'b0000, 1'b0);
        for (int i = 0; i < WIDTH; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        check_val("reload_configured", o_cfgd, 1'b1);

        // Randomized traffic; requests are held until the model grants them.
        req = '0;
        for (int n = 0; n < 600; n++) begin
            rcv = ($urandom_range(0, 15) == 0);
            rax = !rcv && ($urandom_range(0, 7) == 0);
            step(rcv, 8'($urandom), 8'($urandom), 8'($urandom), req, rax);
            req = (req & ~m_last_gnt) | (4'($urandom) & 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lif_neuron_ctrl.md
Name: lif_neuron_ctrl

Overview:
Controller and scheduler for one LIF neuron core (serial-config top: set_vars/expd/w/t/syn in, axon/V out). It accepts a parallel parameter word set (decay, weight, threshold) and serializes it into the neuron over WIDTH cycles. It then shares the single syn input among N_REQ spike requesters with round-robin arbitration. After each axon spike it enforces a refractory window and counts output spikes.

Parameters:
N_REQ, 4, number of presynaptic spike requesters
WIDTH, 8, neuron parameter width = serial load length in cycles
REFRAC_CYC, 4, cycles with no syn grants after an axon pulse (>=1)
CNT_W, 16, output-spike counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  parameter set offered
cfg_ready  out  1  controller can accept a parameter set
cfg_decay  in  WIDTH  decay value, drives expd serially
cfg_weight  in  WIDTH  synaptic weight, drives w serially
cfg_thresh  in  WIDTH  firing threshold, drives t serially
spk_req  in  N_REQ  per-requester spike request, level, held until granted
spk_gnt  out  N_REQ  one-hot grant, combinational, single cycle
set_vars  out  1  to neuron: serial load enable
expd  out  1  to neuron: decay serial bit
w  out  1  to neuron: weight serial bit
t  out  1  to neuron: threshold serial bit
syn  out  1  to neuron: synaptic event pulse
axon  in  1  from neuron: output spike
configured  out  1  neuron holds a valid parameter set
spike_cnt  out  CNT_W  axon pulses counted since reset, saturating

Behaviour:
- States: UNCFG, LOAD, RUN, REFRAC.
- Reset (async, any state): state=UNCFG; set_vars, expd, w, t, syn, configured = 0; spike_cnt = 0; bit counter = 0; RR pointer = requester 0.
- cfg_ready = 1 in UNCFG and RUN; 0 in LOAD and REFRAC. Transfer on cfg_valid & cfg_ready.
- Transfer: capture the three words into shift registers; go to LOAD; configured <= 0.
- LOAD: lasts exactly WIDTH cycles, starting the cycle after the transfer.
  - set_vars = 1 on every LOAD cycle.
  - expd/w/t = LSB of the respective shift register; shift right each cycle, so bit i appears on LOAD cycle i.
  - All outputs registered.
  - After cycle WIDTH-1: set_vars/expd/w/t <= 0, configured <= 1, go to RUN.
- RUN:
  - spk_gnt is the round-robin one-hot pick of spk_req, searching from the RR pointer.
  - spk_gnt = 0 if any of: spk_req = 0, a config transfer is happening this cycle, or axon = 1.
  - On a grant, RR pointer <= granted index + 1 (mod N_REQ).
  - syn <= |spk_gnt, so syn is high the cycle after the grant (1-cycle latency).
  - Continuous requests give one syn pulse per cycle.
- Simultaneous cfg_valid and requests in RUN: config wins; no grant that cycle.
- axon = 1 in RUN:
  - spike_cnt <= spike_cnt + 1, saturating at all-ones.
  - Go to REFRAC with a counter of REFRAC_CYC.
- REFRAC: spk_gnt = 0, syn <= 0. After REFRAC_CYC cycles, return to RUN.
- axon in REFRAC or RUN (not LOAD/UNCFG) is counted. axon in UNCFG or LOAD is ignored.
- Requests in UNCFG, LOAD or REFRAC are not granted. They stay pending, and no request is lost while spk_req is held.
- Reset mid-LOAD: load aborts, configured = 0, and the neuron must be reloaded.
- Back-to-back reconfig is allowed: cfg_ready = 1 in the cycle RUN is entered.

Decomposition:
- Shared package lif_pkg holds:
  - the ctrl_state_t enum (UNCFG, LOAD, RUN, REFRAC);
  - LIF_WIDTH = 8, the default parameter width shared with the neuron top.
- One sub-module: lif_rr_arbiter, parameterized N_REQ.
  - Inputs: req, enable. Outputs: one-hot gnt.
  - Owns the pointer register; clk/rst behave as above.

Test Plan:
- Reset with spk_req=4'b1111, cfg_valid=0 -> all neuron outputs 0, cfg_ready=1, configured=0, spk_gnt=0 indefinitely, spike_cnt=0.
- Config decay=8'hA5, weight=8'h3C, thresh=8'h80 -> set_vars high for exactly 8 cycles. Per cycle: expd 1,0,1,0,0,1,0,1; w 0,0,1,1,1,1,0,0; t 0,0,0,0,0,0,0,1. Then configured=1 and cfg_ready=1.
- In RUN, spk_req=4'b1111 held -> spk_gnt 0001, 0010, 0100, 1000, 0001 on consecutive cycles; syn high each following cycle. With spk_req=4'b0100 only -> gnt 0100 every cycle.
- Force axon=1 for one cycle while spk_req=4'b0011 -> no grant that cycle or the next 4; syn low 5 cycles; spike_cnt=1; grants resume at the RR pointer position.
- cfg_valid with spk_req=4'b0001 in RUN -> no grant that cycle; 8-cycle LOAD with no syn; grant 0001 on the first RUN cycle after.
- Assert rst on LOAD cycle 3 -> set_vars/expd/w/t drop to 0 immediately; state UNCFG; configured=0; a subsequent full load completes normally.
